// File: rtl/count_event_fifo.sv
// count_event_fifo: watches an 8-bit up/down counter and its direction input
// and records wrap-around, threshold-entry and direction-change events. Each
// record {mask, count, timestamp} goes into a small first-word-fall-through
// FIFO that a valid/ready consumer drains. When a record arrives and the FIFO
// is full with no pop, the record is dropped and counted.
module count_event_fifo #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              count_in,
  input  logic                    up_down,
  input  logic [7:0]              threshold,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [12+TS_W-1:0]      evt_data,
  output logic [$clog2(DEPTH):0]  evt_level,
  output logic [7:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 12 + TS_W;

  // Sampled history of the counter, used to evaluate events on the next edge
  logic [7:0]      prev_count_q;
  logic            prev_dir_q;
  logic            prev_vld_q;
  logic [TS_W-1:0] ts_q;

  // FIFO storage. Each pointer has one extra wrap bit so that full and empty
  // can be told apart.
  logic [RW-1:0]   mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     wr_ptr_d;
  logic [AW:0]     rd_ptr_q;
  logic [AW:0]     rd_ptr_d;
  logic [7:0]      drop_cnt_q;
  logic [7:0]      drop_cnt_d;

  logic [3:0]      mask_s;
  logic            empty_s;
  logic            full_s;
  logic            push_s;
  logic            pop_s;
  logic            wr_en_s;

  // Event detection against the previous sample (suppressed until a sample exists)
  always_comb begin
    mask_s = 4'b0000;
    if (prev_vld_q) begin
      mask_s[0] = (prev_count_q == 8'hFF) && (count_in == 8'h00);
      mask_s[1] = (prev_count_q == 8'h00) && (count_in == 8'hFF);
      mask_s[2] = (count_in == threshold) && (count_in != prev_count_q);
      mask_s[3] = (up_down != prev_dir_q);
    end else begin
      mask_s = 4'b0000;
    end
  end

  // FIFO status and handshake decode.
  // A pop from a full FIFO frees a slot on the same edge, so the push still goes in.
  always_comb begin
    empty_s = (wr_ptr_q == rd_ptr_q);
    full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push_s  = (mask_s != 4'b0000);
    pop_s   = (!empty_s) && evt_ready;
    wr_en_s = push_s && ((!full_s) || pop_s);
  end

  // Next-state for the pointers and the saturating drop counter
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && full_s && !pop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Sequential state: counter history, timestamp, FIFO pointers, storage and drop count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_count_q <= 8'h00;
      prev_dir_q   <= 1'b0;
      prev_vld_q   <= 1'b0;
      ts_q         <= {TS_W{1'b0}};
      wr_ptr_q     <= {(AW+1){1'b0}};
      rd_ptr_q     <= {(AW+1){1'b0}};
      drop_cnt_q   <= 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {RW{1'b0}};
      end
    end else begin
      prev_count_q <= count_in;
      prev_dir_q   <= up_down;
      prev_vld_q   <= 1'b1;
      ts_q         <= ts_q + {{(TS_W-1){1'b0}}, 1'b1};
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_cnt_q   <= drop_cnt_d;
      if (wr_en_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= {mask_s, count_in, ts_q};
      end
    end
  end

  // Outputs come straight from registers. The head is shown whenever the FIFO
  // is not empty, and zero is shown when it is empty.
  always_comb begin
    evt_valid = !empty_s;
    evt_level = wr_ptr_q - rd_ptr_q;
    drop_cnt  = drop_cnt_q;
    if (empty_s) begin
      evt_data = {RW{1'b0}};
    end else begin
      evt_data = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_count_event_fifo.sv
// Self-checking bench for count_event_fifo (DEPTH=4, TS_W=8) using a
// record scoreboard plus per-scenario checks.
module tb_count_event_fifo;

  logic        clk;
  logic        reset;
  logic [7:0]  count_in;
  logic        up_down;
  logic [7:0]  threshold;
  logic        evt_valid;
  logic        evt_ready;
  logic [19:0] evt_data;
  logic [2:0]  evt_level;
  logic [7:0]  drop_cnt;

  count_event_fifo #(.DEPTH(4), .TS_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .up_down   (up_down),
    .threshold (threshold),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .evt_level (evt_level),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;

  // reference model state
  logic [19:0] sb[$];
  logic [19:0] popped_q[$];
  logic [7:0]  prev_c_m;
  logic        prev_d_m;
  logic        prev_v_m;
  logic [7:0]  ts_m;
  int          drops_m;
  logic [7:0]  thr;

  task automatic model_clear();
    sb.delete();
    prev_c_m = 8'h00;
    prev_d_m = 1'b0;
    prev_v_m = 1'b0;
    ts_m     = 8'h00;
    drops_m  = 0;
  endtask

  // Assert reset for two edges and release it between a rising and a falling edge
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // One clock: drive inputs, check DUT against the scoreboard, advance the model
  task automatic step(input logic [7:0] c, input logic d, input logic rdy);
    logic [3:0] m;
    @(negedge clk);
    count_in  = c;
    up_down   = d;
    evt_ready = rdy;
    threshold = thr;
    #1;
    tests_run++;
    if (evt_valid !== (sb.size() != 0)) begin
      fails++;
      $display("FAIL step_valid: got %b want %b at %0t", evt_valid, (sb.size() != 0), $time);
    end
    tests_run++;
    if (evt_level !== 3'(sb.size())) begin
      fails++;
      $display("FAIL step_level: got %0d want %0d at %0t", evt_level, sb.size(), $time);
    end
    tests_run++;
    if (drop_cnt !== 8'(drops_m)) begin
      fails++;
      $display("FAIL step_drop: got %0d want %0d at %0t", drop_cnt, drops_m, $time);
    end
    tests_run++;
    if (sb.size() != 0) begin
      if (evt_data !== sb[0]) begin
        fails++;
        $display("FAIL step_head: got %h want %h at %0t", evt_data, sb[0], $time);
      end
      if (rdy) begin
        popped_q.push_back(evt_data);
        void'(sb.pop_front());
      end
    end else begin
      if (evt_data !== 20'h00000) begin
        fails++;
        $display("FAIL step_empty_data: got %h want 00000 at %0t", evt_data, $time);
      end
    end
    m = 4'b0000;
    if (prev_v_m) begin
      m[0] = (prev_c_m == 8'hFF) && (c == 8'h00);
      m[1] = (prev_c_m == 8'h00) && (c == 8'hFF);
      m[2] = (c == thr) && (c != prev_c_m);
      m[3] = (d != prev_d_m);
    end
    if (m != 4'b0000) begin
      if (sb.size() < 4) sb.push_back({m, c, ts_m});
      else if (drops_m < 255) drops_m++;
    end
    prev_c_m = c;
    prev_d_m = d;
    prev_v_m = 1'b1;
    ts_m     = ts_m + 8'd1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++;
    if (evt_valid !== 1'b0 || evt_level !== 3'd0 || evt_data !== 20'h0 || drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_state: got valid=%b level=%0d data=%h drop=%0d want 0/0/0/0",
               evt_valid, evt_level, evt_data, drop_cnt);
    end
  endtask

  task automatic test_wrap_up();
    logic [7:0] ramp [8];
    ramp = '{8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1};
    do_reset();
    popped_q.delete();
    thr = 8'd100;
    for (int i = 0; i < 8; i++) step(ramp[i], 1'b1, 1'b1);
    repeat (2) step(8'd1, 1'b1, 1'b1);
    tests_run++;
    if (popped_q.size() != 1 || popped_q[0] !== {4'b0001, 8'h00, 8'd6} || drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL wrap_up: got n=%0d rec=%h drop=%0d want n=1 rec=10006 drop=0",
               popped_q.size(), popped_q[0], drop_cnt);
    end
  endtask

  task automatic test_wrap_down();
    do_reset();
    popped_q.delete();
    thr = 8'd100;
    step(8'd2, 1'b0, 1'b1);
    step(8'd2, 1'b0, 1'b1);
    step(8'd1, 1'b0, 1'b1);
    step(8'd0, 1'b0, 1'b1);
    step(8'd255, 1'b0, 1'b1);
    repeat (2) step(8'd255, 1'b0, 1'b1);
    tests_run++;
    if (popped_q.size() != 1 || popped_q[0] !== {4'b0010, 8'hFF, 8'd4}) begin
      fails++;
      $display("FAIL wrap_down: got n=%0d rec=%h want n=1 rec=2FF04", popped_q.size(), popped_q[0]);
    end
  endtask

  task automatic test_merge();
    do_reset();
    popped_q.delete();
    thr = 8'd0;
    step(8'd254, 1'b1, 1'b1);
    step(8'd255, 1'b1, 1'b1);
    step(8'd0, 1'b1, 1'b1);
    repeat (5) step(8'd0, 1'b1, 1'b1);
    tests_run++;
    if (popped_q.size() != 1 || popped_q[0] !== {4'b0101, 8'h00, 8'd2}) begin
      fails++;
      $display("FAIL merge_hold: got n=%0d rec=%h want n=1 rec=50002", popped_q.size(), popped_q[0]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    popped_q.delete();
    thr = 8'd100;
    step(8'd10, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(8'd10, (i % 2 == 0), 1'b0);
    step(8'd10, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (evt_level !== 3'd4 || drop_cnt !== 8'd2) begin
      fails++;
      $display("FAIL overflow_level: got level=%0d drop=%0d want 4/2", evt_level, drop_cnt);
    end
    repeat (5) step(8'd10, 1'b0, 1'b1);
    tests_run++;
    if (popped_q.size() != 4) begin
      fails++;
      $display("FAIL overflow_count: got %0d want 4", popped_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (popped_q[i] !== {4'b1000, 8'd10, 8'(i + 1)}) begin
          fails++;
          $display("FAIL overflow_rec%0d: got %h want %h", i, popped_q[i], {4'b1000, 8'd10, 8'(i + 1)});
        end
      end
    end
  endtask

  task automatic test_full_push_pop();
    popped_q.delete();
    step(8'd10, 1'b1, 1'b0);
    step(8'd10, 1'b0, 1'b0);
    step(8'd10, 1'b1, 1'b0);
    step(8'd10, 1'b0, 1'b0);
    step(8'd10, 1'b1, 1'b1);
    #1;
    tests_run++;
    if (evt_level !== 3'd4 || drop_cnt !== 8'd2) begin
      fails++;
      $display("FAIL full_push_pop: got level=%0d drop=%0d want 4/2", evt_level, drop_cnt);
    end
    repeat (5) step(8'd10, 1'b1, 1'b1);
    tests_run++;
    if (popped_q.size() != 5 || popped_q[0] !== {4'b1000, 8'd10, 8'd13} ||
        popped_q[4] !== {4'b1000, 8'd10, 8'd17}) begin
      fails++;
      $display("FAIL full_order: got n=%0d first=%h last=%h want n=5 first=80A0D last=80A11",
               popped_q.size(), popped_q[0], popped_q[4]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    popped_q.delete();
    thr = 8'd100;
    step(8'd20, 1'b0, 1'b0);
    step(8'd20, 1'b1, 1'b0);
    step(8'd20, 1'b0, 1'b0);
    step(8'd20, 1'b1, 1'b0);
    step(8'd21, 1'b1, 1'b0);
    #1;
    tests_run++;
    if (evt_level !== 3'd3) begin
      fails++;
      $display("FAIL mid_prefill: got level=%0d want 3", evt_level);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (evt_valid !== 1'b0 || evt_level !== 3'd0 || drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL mid_async: got valid=%b level=%0d drop=%0d want 0/0/0", evt_valid, evt_level, drop_cnt);
    end
    do_reset();
    step(8'd77, 1'b1, 1'b1);
    step(8'd77, 1'b1, 1'b1);
    #1;
    tests_run++;
    if (evt_valid !== 1'b0 || evt_level !== 3'd0 || popped_q.size() != 0) begin
      fails++;
      $display("FAIL mid_first_edge: got valid=%b level=%0d pops=%0d want 0/0/0",
               evt_valid, evt_level, popped_q.size());
    end
  endtask

  initial begin
    reset     = 1'b0;
    count_in  = 8'h00;
    up_down   = 1'b0;
    threshold = 8'd100;
    evt_ready = 1'b0;
    thr       = 8'd100;
    model_clear();
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_merge();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/count_event_fifo.md
Name: count_event_fifo

Overview:
- Downstream consumer of the 8-bit up/down counter.
- Samples the counter value and its direction input every clock, detects events, and queues each event record in a small FIFO.
- Events detected: wrap-around, threshold match, direction change.
- Records carry a cycle timestamp and are drained by a valid/ready consumer, such as a logger or bus bridge.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, minimum 2.
- TS_W, 8, width of the free-running timestamp counter.

Ports:
- clk  input  1  rising-edge clock, same domain as the counter.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- count_in  input  8  counter value (counter `out`).
- up_down  input  1  direction driven to the counter: 1 = up, 0 = down.
- threshold  input  8  match value; quasi-static.
- evt_valid  output  1  FIFO head holds a valid record.
- evt_ready  input  1  consumer accepts the head this cycle.
- evt_data  output  12+TS_W  record = {mask[3:0], count[7:0], ts[TS_W-1:0]}.
- evt_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  output  8  records lost to overflow; saturates at 255.

Behaviour:
- Reset (reset=0, async): all internal state clears.
  - prev_count=0, prev_dir=0, prev_vld=0, ts=0.
  - FIFO empty; evt_valid=0, evt_data=0, evt_level=0, drop_cnt=0.
- Timestamp: ts increments every clock and wraps modulo 2^TS_W.
- Sampling at each rising edge:
  - prev_count<=count_in, prev_dir<=up_down, prev_vld<=1.
  - No event is evaluated while prev_vld=0, i.e. the first edge after reset release.
- Event mask bits, evaluated combinationally against prev_* when prev_vld=1:
  - mask[0] WRAP_UP: prev_count==255 and count_in==0.
  - mask[1] WRAP_DN: prev_count==0 and count_in==255.
  - mask[2] MATCH: count_in==threshold and count_in!=prev_count (fires on entry only, not while holding).
  - mask[3] DIR: up_down!=prev_dir.
- Several events in one cycle produce ONE record with multiple mask bits set.
- Push: mask!=0 at edge k writes {mask, count_in, ts} at edge k.
  - ts is its value before that edge's increment.
  - evt_valid is high in the cycle after edge k, giving 1-cycle latency.
- Pop: occurs when evt_valid && evt_ready at an edge; the head advances.
  - evt_data is first-word fall-through: it always shows the head.
  - evt_data is 0 when empty.
- No bypass: a push into an empty FIFO is never visible in the same cycle.
- Full with a simultaneous pop and push: both happen; level stays DEPTH.
- Full with a push and no pop: the record is dropped; drop_cnt increments, saturating at 255; FIFO contents are unchanged.
- Empty with evt_ready=1: no effect; level never underflows.
- Record order is strictly FIFO.
- Pointers use DEPTH modulo arithmetic with an extra wrap bit; full and empty derive from those pointers.
- Reset asserted mid-operation: FIFO is flushed, drop_cnt=0, ts=0.
  - Any partially held handshake is abandoned; the consumer sees evt_valid=0 asynchronously.

Test Plan:
- Reset, then count_in ramps 250..255,0,1 with up_down=1, threshold=100, evt_ready=1 -> exactly one record: mask=0001, count=0x00; drop_cnt=0.
- Down ramp 2,1,0,255 with up_down=0 held from before the ramp -> one record: mask=0010, count=0xFF.
- threshold=0, up-count 255->0 -> single record with mask=0101, count=0x00 (WRAP_UP+MATCH merged); holding count_in at 0 for 5 cycles adds no records.
- evt_ready=0, toggle up_down on 6 consecutive cycles, DEPTH=4 -> evt_level=4, drop_cnt=2; then evt_ready=1 -> 4 records pop in order, each mask=1000, timestamps strictly consecutive.
- FIFO full, evt_ready=1 and a new event on the same edge -> level stays 4, drop_cnt unchanged, new record appears last.
- reset pulled to 0 mid-ramp with 3 entries queued -> evt_valid=0 and evt_level=0 immediately (before next edge); first edge after release produces no record even if count_in differs from 0.
